// File: rtl/keystream_sched_if.sv
// Keystream request/acknowledge bundle shared by the UART TX (encrypt) and RX (decrypt) paths.
// The master side is the requester pair; the slave side is the scheduler.
interface keystream_sched_if;
  logic       tx_req;
  logic       tx_ack;
  logic [7:0] tx_key;
  logic       rx_req;
  logic       rx_ack;
  logic [7:0] rx_key;

  modport master (
    output tx_req, rx_req,
    input  tx_ack, tx_key, rx_ack, rx_key
  );

  modport slave (
    input  tx_req, rx_req,
    output tx_ack, tx_key, rx_ack, rx_key
  );
endinterface

// File: rtl/keystream_sched.sv
// Sequences the shared 128-bit keystream LFSR: discards a warm-up run after reset, then hands
// out one byte per STEPS_PER_BYTE steps to the TX and RX paths under round-robin arbitration.
module keystream_sched #(
  parameter int WARMUP_STEPS   = 128,
  parameter int STEPS_PER_BYTE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             lfsr_en,
  input  logic [127:0]     lfsr_state,
  keystream_sched_if.slave ks,
  output logic             ready,
  output logic             busy,
  output logic [15:0]      tx_count,
  output logic [15:0]      rx_count
);

  localparam int WW = (WARMUP_STEPS < 1) ? 1 : $clog2(WARMUP_STEPS + 1);
  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_STEPS);
  localparam logic [7:0]    STEP_LAST = 8'(STEPS_PER_BYTE);

  typedef enum logic [1:0] {WARM, IDLE, STEP, SETTLE} state_t;

  state_t        state, state_d;
  logic [WW-1:0] warm_cnt;
  logic [7:0]    step_cnt;
  logic          gnt_rx;
  logic          last_rx;
  logic          warm_done, step_done, any_req, pick_rx;
  logic          lfsr_en_d, grant, deliver;
  logic          unused_state;

  assign warm_done = (warm_cnt == WARM_LAST);
  assign step_done = (step_cnt == STEP_LAST);
  assign any_req   = ks.tx_req | ks.rx_req;
  // On a tie the requester not served last wins; a lone request always wins.
  assign pick_rx   = (ks.tx_req & ks.rx_req) ? ~last_rx : ks.rx_req;
  assign busy      = (state != IDLE);
  assign unused_state = ^lfsr_state[127:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WARM;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      WARM:    if (warm_done) state_d = IDLE;
      IDLE:    if (any_req)   state_d = STEP;
      STEP:    if (step_done) state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = WARM;
    endcase
  end

  always_comb begin
    lfsr_en_d = 1'b0;
    grant     = 1'b0;
    deliver   = 1'b0;
    case (state)
      WARM:    lfsr_en_d = ~warm_done;
      IDLE: begin
        grant     = any_req;
        lfsr_en_d = any_req;
      end
      STEP:    lfsr_en_d = ~step_done;
      SETTLE:  deliver   = 1'b1;
      default: lfsr_en_d = 1'b0;
    endcase
  end

  // The key byte is taken at the end of SETTLE, when lfsr_state holds every step of this byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_en   <= 1'b0;
      ready     <= 1'b0;
      warm_cnt  <= '0;
      step_cnt  <= 8'd0;
      gnt_rx    <= 1'b0;
      last_rx   <= 1'b1;
      ks.tx_ack <= 1'b0;
      ks.rx_ack <= 1'b0;
      ks.tx_key <= 8'h00;
      ks.rx_key <= 8'h00;
      tx_count  <= 16'd0;
      rx_count  <= 16'd0;
    end else begin
      lfsr_en   <= lfsr_en_d;
      ready     <= (state_d != WARM);
      ks.tx_ack <= deliver & ~gnt_rx;
      ks.rx_ack <= deliver & gnt_rx;
      if (state == WARM && !warm_done) warm_cnt <= warm_cnt + WW'(1);
      if (grant) begin
        step_cnt <= 8'd1;
        gnt_rx   <= pick_rx;
        last_rx  <= pick_rx;
      end else if (state == STEP && !step_done) begin
        step_cnt <= step_cnt + 8'd1;
      end
      if (deliver && !gnt_rx) begin
        ks.tx_key <= lfsr_state[7:0];
        tx_count  <= tx_count + 16'd1;
      end
      if (deliver && gnt_rx) begin
        ks.rx_key <= lfsr_state[7:0];
        rx_count  <= rx_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_keystream_sched.sv
// Directed bench for keystream_sched: a behavioural LFSR on lfsr_en feeds the scheduler,
// and expected key bytes come from a software model of the same LFSR stepped from the key.
module tb_keystream_sched;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         lfsr_en;
  logic [127:0] lfsr_state;
  logic         ready, busy;
  logic [15:0]  tx_count, rx_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  localparam logic [127:0] KEY = 128'h0123456789ABCDEF_FEDCBA9876543210;

  keystream_sched_if ks();

  keystream_sched #(.WARMUP_STEPS(128), .STEPS_PER_BYTE(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lfsr_en    (lfsr_en),
    .lfsr_state (lfsr_state),
    .ks         (ks),
    .ready      (ready),
    .busy       (busy),
    .tx_count   (tx_count),
    .rx_count   (rx_count)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] lfsr_step(input logic [127:0] s);
    logic fb;
    fb = s[127] ^ s[29] ^ s[27] ^ s[2];
    return {fb, s[127:1]};
  endfunction

  function automatic logic [7:0] model_byte(input int n);
    logic [127:0] s;
    s = KEY;
    for (int i = 0; i < n; i++) s = lfsr_step(s);
    return s[7:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       lfsr_state <= KEY;
    else if (lfsr_en) lfsr_state <= lfsr_step(lfsr_state);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    ks.tx_req = 1'b0;
    ks.rx_req = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic wait_ready;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (ready) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_ready: ready=%0b after 300 cycles, required 1", ready);
    end
  endtask

  task automatic test_reset;
    int warm_en, first_en, last_en, rdy_cyc, ack_cyc, extra;
    logic [7:0] key;
    warm_en = 0; first_en = -1; last_en = -1; rdy_cyc = -1; ack_cyc = -1; extra = 0; key = 8'h00;
    rst_n = 1'b0;
    ks.tx_req = 1'b0;
    ks.rx_req = 1'b0;
    tick;
    tick;
    checks++;
    if ({lfsr_en, ready, busy, ks.tx_ack, ks.rx_ack, ks.tx_key, ks.rx_key, tx_count, rx_count}
        !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 16'h0000}) begin
      failures++;
      $display("FAIL reset_values: en=%0b rdy=%0b busy=%0b acks=%0b%0b keys=%h/%h counts=%0d/%0d",
               lfsr_en, ready, busy, ks.tx_ack, ks.rx_ack, ks.tx_key, ks.rx_key, tx_count, rx_count);
    end
    rst_n = 1'b1;
    cyc = 0;
    checks++;
    if ({lfsr_en, ready} !== 2'b00) begin
      failures++;
      $display("FAIL cycle0: en=%0b ready=%0b, required 0/0", lfsr_en, ready);
    end
    while (cyc < 170) begin
      tick;
      if (lfsr_en && !ready) begin
        warm_en++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end
      if (ready && rdy_cyc < 0) rdy_cyc = cyc;
      if (ks.rx_ack) extra++;
      if (ks.tx_ack) begin
        if (ack_cyc < 0) begin
          ack_cyc = cyc;
          key = ks.tx_key;
        end else extra++;
        ks.tx_req = 1'b0;
      end
      if (cyc == 5) ks.tx_req = 1'b1;
    end
    checks++;
    if (warm_en != 128) begin failures++; $display("FAIL warm_en_count: got %0d required 128", warm_en); end
    checks++;
    if (first_en != 1 || last_en != 128) begin
      failures++;
      $display("FAIL warm_en_window: got %0d..%0d required 1..128", first_en, last_en);
    end
    checks++;
    if (rdy_cyc != 129) begin failures++; $display("FAIL ready_cycle: got %0d required 129", rdy_cyc); end
    checks++;
    if (ack_cyc != 139) begin failures++; $display("FAIL held_req_ack: got cycle %0d required 139", ack_cyc); end
    checks++;
    if (key !== model_byte(136)) begin
      failures++;
      $display("FAIL held_req_key: got %h required %h", key, model_byte(136));
    end
    checks++;
    if (extra != 0 || tx_count !== 16'd1 || busy !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL after_warm: extra=%0d tx_count=%0d busy=%0b ready=%0b required 0/1/0/1",
               extra, tx_count, busy, ready);
    end
  endtask

  task automatic test_single_tx;
    int t, ack_cyc, acks, rx_acks, en_cnt, en_first, en_last;
    logic [7:0] key;
    ack_cyc = -1; acks = 0; rx_acks = 0; en_cnt = 0; en_first = -1; en_last = -1; key = 8'h00;
    apply_reset;
    wait_ready;
    t = cyc;
    ks.tx_req = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick;
      if (lfsr_en) begin
        en_cnt++;
        if (en_first < 0) en_first = cyc;
        en_last = cyc;
      end
      if (ks.rx_ack) rx_acks++;
      if (ks.tx_ack) begin
        acks++;
        ack_cyc = cyc;
        key = ks.tx_key;
        ks.tx_req = 1'b0;
      end
    end
    checks++;
    if (ack_cyc != t + 10 || acks != 1) begin
      failures++;
      $display("FAIL single_ack: got cycle %0d count %0d required cycle %0d count 1", ack_cyc, acks, t + 10);
    end
    checks++;
    if (en_cnt != 8 || en_first != t + 1 || en_last != t + 8) begin
      failures++;
      $display("FAIL single_steps: got %0d steps %0d..%0d required 8 steps %0d..%0d",
               en_cnt, en_first, en_last, t + 1, t + 8);
    end
    checks++;
    if (key !== model_byte(136)) begin
      failures++;
      $display("FAIL single_key: got %h required %h", key, model_byte(136));
    end
    checks++;
    if (ks.tx_key !== key || tx_count !== 16'd1 || rx_count !== 16'd0 || rx_acks != 0) begin
      failures++;
      $display("FAIL single_state: key_hold=%h tx_count=%0d rx_count=%0d rx_acks=%0d required %h/1/0/0",
               ks.tx_key, tx_count, rx_count, rx_acks, key);
    end
  endtask

  task automatic test_contention;
    int t, n, both;
    int ev_cyc[8];
    bit ev_rx[8];
    logic [7:0] ev_key[8];
    n = 0; both = 0;
    for (int k = 0; k < 8; k++) begin ev_cyc[k] = -1; ev_rx[k] = 1'b0; ev_key[k] = 8'h00; end
    apply_reset;
    wait_ready;
    t = cyc;
    ks.tx_req = 1'b1;
    ks.rx_req = 1'b1;
    for (int i = 1; i <= 55; i++) begin
      tick;
      if (ks.tx_ack && ks.rx_ack) both++;
      if ((ks.tx_ack || ks.rx_ack) && n < 8) begin
        ev_cyc[n] = cyc;
        ev_rx[n] = ks.rx_ack;
        ev_key[n] = ks.rx_ack ? ks.rx_key : ks.tx_key;
        n++;
      end
      if (i == 40) begin
        ks.tx_req = 1'b0;
        ks.rx_req = 1'b0;
      end
    end
    checks++;
    if (n != 4 || both != 0) begin
      failures++;
      $display("FAIL contention_count: got %0d acks (%0d simultaneous) required 4 (0)", n, both);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ev_cyc[k] != t + 10 * (k + 1) || ev_rx[k] != bit'(k % 2) || ev_key[k] !== model_byte(136 + 8 * k)) begin
        failures++;
        $display("FAIL contention_ack%0d: got cycle %0d rx=%0b key %h required cycle %0d rx=%0b key %h",
                 k, ev_cyc[k], ev_rx[k], ev_key[k], t + 10 * (k + 1), k % 2, model_byte(136 + 8 * k));
      end
    end
    checks++;
    if (tx_count !== 16'd2 || rx_count !== 16'd2) begin
      failures++;
      $display("FAIL contention_counts: got tx=%0d rx=%0d required 2/2", tx_count, rx_count);
    end
  endtask

  task automatic test_withdraw;
    int t, ack_cyc, acks;
    logic [7:0] key;
    ack_cyc = -1; acks = 0; key = 8'h00;
    apply_reset;
    wait_ready;
    t = cyc;
    ks.tx_req = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick;
      if (i == 1) ks.tx_req = 1'b0;
      if (ks.tx_ack || ks.rx_ack) begin
        acks++;
        ack_cyc = cyc;
        key = ks.tx_key;
      end
    end
    checks++;
    if (ack_cyc != t + 10 || acks != 1) begin
      failures++;
      $display("FAIL withdraw_ack: got cycle %0d count %0d required cycle %0d count 1", ack_cyc, acks, t + 10);
    end
    checks++;
    if (key !== model_byte(136) || busy !== 1'b0 || tx_count !== 16'd1) begin
      failures++;
      $display("FAIL withdraw_state: key=%h busy=%0b tx_count=%0d required %h/0/1",
               key, busy, tx_count, model_byte(136));
    end
  endtask

  task automatic test_reset_mid_step;
    int t, rdy_cyc, ack_cyc;
    logic [7:0] key;
    rdy_cyc = -1; ack_cyc = -1; key = 8'h00;
    apply_reset;
    wait_ready;
    t = cyc;
    ks.tx_req = 1'b1;
    for (int i = 0; i < 4; i++) tick;
    checks++;
    if (lfsr_en !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_step_active: en=%0b busy=%0b required 1/1", lfsr_en, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({lfsr_en, ready, busy, ks.tx_ack, ks.rx_ack, ks.tx_key, ks.rx_key, tx_count, rx_count}
        !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 16'h0000}) begin
      failures++;
      $display("FAIL mid_step_reset: en=%0b rdy=%0b busy=%0b acks=%0b%0b keys=%h/%h counts=%0d/%0d",
               lfsr_en, ready, busy, ks.tx_ack, ks.rx_ack, ks.tx_key, ks.rx_key, tx_count, rx_count);
    end
    tick;
    tick;
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 160) begin
      tick;
      if (ready && rdy_cyc < 0) rdy_cyc = cyc;
      if (ks.tx_ack && ack_cyc < 0) begin
        ack_cyc = cyc;
        key = ks.tx_key;
        ks.tx_req = 1'b0;
      end
    end
    checks++;
    if (rdy_cyc != 129 || ack_cyc != 139) begin
      failures++;
      $display("FAIL rewarm_timing: got ready %0d ack %0d required 129/139", rdy_cyc, ack_cyc);
    end
    checks++;
    if (key !== model_byte(136) || tx_count !== 16'd1) begin
      failures++;
      $display("FAIL rewarm_key: got %h count %0d required %h count 1", key, tx_count, model_byte(136));
    end
  endtask

  task automatic test_count_wrap;
    bit got;
    apply_reset;
    wait_ready;
    ks.rx_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick;
      if (ks.rx_ack) begin
        got = 1'b1;
        ks.rx_req = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) tick;
    force dut.tx_count = 16'hFFFF;
    #1;
    release dut.tx_count;
    #1;
    checks++;
    if (tx_count !== 16'hFFFF || rx_count !== 16'd1 || !got) begin
      failures++;
      $display("FAIL wrap_setup: tx_count=%h rx_count=%0d rx_ack_seen=%0b required FFFF/1/1", tx_count, rx_count, got);
    end
    ks.tx_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick;
      if (ks.tx_ack) begin
        got = 1'b1;
        ks.tx_req = 1'b0;
      end
    end
    checks++;
    if (!got || tx_count !== 16'h0000 || rx_count !== 16'd1) begin
      failures++;
      $display("FAIL wrap_result: ack=%0b tx_count=%h rx_count=%0d required 1/0000/1", got, tx_count, rx_count);
    end
  endtask

  initial begin
    ks.tx_req = 1'b0;
    ks.rx_req = 1'b0;
    test_reset;
    test_single_tx;
    test_contention;
    test_withdraw;
    test_reset_mid_step;
    test_count_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keystream_sched.md
# keystream_sched

Sequences the 128-bit keystream LFSR and shares it between the UART transmit (encrypt) and receive (decrypt) paths. After reset, it runs a warm-up phase that steps the LFSR a fixed number of times and discards the output. It then serves byte-wide keystream requests from the two requesters with round-robin arbitration, advancing the LFSR a fixed number of steps per delivered byte. The block sits between the LFSR and the XOR stages of the serial security wrapper, and drives the LFSR's `enable` input exclusively.

## Interface
- `WARMUP_STEPS`, default 128: LFSR steps discarded after reset before any byte is served; 0 allowed.
- `STEPS_PER_BYTE`, default 8: LFSR steps per delivered byte; range 1..255.
- `clk`, in, 1: system clock (3.125 MHz); the only clock.
- `rst_n`, in, 1: asynchronous, active-low reset. It is shared with the LFSR, so both restart together.
- `lfsr_en`, out, 1: drives the LFSR `enable` input. Registered; reset 0.
- `lfsr_state`, in, 128: current LFSR `out` value.
- `tx_req`, in, 1: transmit path requests one keystream byte (level).
- `tx_ack`, out, 1: one-cycle pulse; `tx_key` is valid in the same cycle. Reset 0.
- `tx_key`, out, 8: keystream byte for TX. Holds its value until the next TX ack. Reset 8'h00.
- `rx_req`, in, 1: receive path requests one keystream byte (level).
- `rx_ack`, out, 1: one-cycle pulse; `rx_key` is valid in the same cycle. Reset 0.
- `rx_key`, out, 8: keystream byte for RX. Holds its value until the next RX ack. Reset 8'h00.
- `ready`, out, 1: warm-up is complete. Reset 0.
- `busy`, out, 1: FSM is not in IDLE. Reset 1.
- `tx_count`, out, 16: TX bytes delivered; wraps from 16'hFFFF to 0. Reset 0.
- `rx_count`, out, 16: RX bytes delivered; wraps from 16'hFFFF to 0. Reset 0.

## Operation
- FSM states:
  - WARM (reset state): `lfsr_en`=1 for WARMUP_STEPS cycles, then go to IDLE and set `ready`=1. `ready` never falls again until the next reset.
  - IDLE: sample the requests. If any request is pending, grant one, go to STEP and set `lfsr_en`=1.
  - STEP: hold `lfsr_en`=1 for exactly STEPS_PER_BYTE cycles (8-bit step counter), then clear `lfsr_en` and go to SETTLE.
  - SETTLE: one cycle. `lfsr_state` now reflects all steps; capture `lfsr_state[7:0]` into the granted `*_key`. At the next edge, pulse the granted `*_ack`, increment the granted `*_count`, and go to IDLE.
- Arbitration:
  - A `last_grant` pointer resets to RX, so TX wins the first tie.
  - When both requests are high in IDLE, grant the requester that was not granted last.
  - When only one request is high, grant that one.
  - Requests arriving in WARM are held off, not lost. No ack is issued before `ready`=1.
- Handshake:
  - A requester keeps `req` high until it sees `ack`.
  - If `req` is still high in the ack cycle, it counts as a new request, sampled at the end of that cycle.
  - Once a grant is taken, the byte is delivered and the ack pulses even if `req` drops before then.
- `lfsr_en` is 0 in IDLE and SETTLE. The LFSR never advances except in WARM or STEP, so the TX and RX keystreams stay aligned with the peer device.
- Bytes are drawn from one shared stream. A byte goes to exactly one requester; no byte is duplicated or skipped.
- Reset mid-operation: all outputs return to reset values, and any in-flight grant is dropped with no ack. The LFSR reloads its key on the same reset, and warm-up restarts.

## Timing
- Cycle 0 is the first cycle after `rst_n` rises.
- `lfsr_en` is high in cycles 1..WARMUP_STEPS, and `ready` rises in cycle WARMUP_STEPS+1. If WARMUP_STEPS=0, `ready` rises in cycle 1 and `lfsr_en` stays 0.
- Request to ack: with `req` first sampled in IDLE at the end of cycle t:
  - `lfsr_en` is high in cycles t+1 .. t+STEPS_PER_BYTE.
  - SETTLE is cycle t+STEPS_PER_BYTE+1.
  - `ack` and `key` are valid in cycle t+STEPS_PER_BYTE+2.
- The FSM is in IDLE during the ack cycle, so a follow-on grant is possible at the end of that cycle.
- Throughput is one byte per STEPS_PER_BYTE+2 cycles (10 cycles by default).
- `busy`=0 only in IDLE. `*_count` updates in the same cycle as its `ack`.

## Test plan
- Reset and warm-up with defaults:
  - `lfsr_en` is high for exactly 128 cycles (1..128), and `ready` rises in cycle 129.
  - `tx_req` held from cycle 5 gets `tx_ack` in cycle 139.
- Single TX byte: after `ready`, assert `tx_req` at cycle t.
  - `tx_ack` pulses once in cycle t+10.
  - `tx_key` equals bits [7:0] of a software model of the 128-bit LFSR (feedback = bits 127^29^27^2, shift right, feedback into bit 127) after 136 steps.
  - `tx_count`=1.
- Contention: hold `tx_req` and `rx_req` high continuously for 40 cycles after `ready`.
  - Acks alternate TX, RX, TX, RX at 10-cycle spacing.
  - The keys match consecutive model bytes after 136, 144, 152 and 160 steps.
- Request withdrawal: drop `tx_req` one cycle after it is granted.
  - `tx_ack` still pulses at t+10.
  - No second grant follows.
- Reset mid-STEP: assert `rst_n`=0 in the 4th STEP cycle.
  - All outputs return to reset values with no ack.
  - After release, warm-up repeats, and the first byte again equals the model after 136 steps.
- Counter wrap: force `tx_count` to 16'hFFFF, or run 65536 TX bytes with STEPS_PER_BYTE=1 and WARMUP_STEPS=0.
  - The next ack yields `tx_count`=0.
  - `rx_count` is unchanged.
